// File: rtl/draw_instruction_executor_pkg.sv
// Shared constants, instruction layout and FSM encoding for the draw instruction executor.
// The span counter and the top-level FSM both use these definitions.
package draw_instruction_executor_pkg;

    localparam int X_WIDTH       = 8;
    localparam int Y_WIDTH       = 7;
    localparam int COLOUR_WIDTH  = 3;
    localparam int RESULT_WIDTH  = 8;
    localparam int SCREEN_WIDTH  = 160;
    localparam int SCREEN_HEIGHT = 120;

    localparam logic [X_WIDTH-1:0] X_MAX = X_WIDTH'(SCREEN_WIDTH - 1);
    localparam logic [Y_WIDTH-1:0] Y_MAX = Y_WIDTH'(SCREEN_HEIGHT - 1);

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_PLOT  = 4'd1;
    localparam logic [3:0] OP_HLINE = 4'd2;
    localparam logic [3:0] OP_CLEAR = 4'd3;

    localparam logic [RESULT_WIDTH-1:0] RES_OK         = 8'd0;
    localparam logic [RESULT_WIDTH-1:0] RES_BAD_OPCODE = 8'd1;
    localparam logic [RESULT_WIDTH-1:0] RES_RANGE      = 8'd2;
    localparam logic [RESULT_WIDTH-1:0] RES_CLIPPED    = 8'd3;

    localparam int OPCODE_LSB  = 28;
    localparam int ARG_LSB     = 19;
    localparam int PLOT_EN_BIT = 18;
    localparam int COLOUR_LSB  = 15;
    localparam int Y_LSB       = 8;
    localparam int X_LSB       = 0;

    // Field order mirrors the bit positions above, MSB first.
    typedef struct packed {
        logic [3:0]              op;
        logic [8:0]              arg;
        logic                    plot_en;
        logic [COLOUR_WIDTH-1:0] colour;
        logic [Y_WIDTH-1:0]      y;
        logic [X_WIDTH-1:0]      x;
    } instr_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PIXEL = 3'd1;
    localparam logic [2:0] ST_SPAN  = 3'd2;
    localparam logic [2:0] ST_CLEAR = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    function automatic logic on_screen(input logic [X_WIDTH-1:0] x, input logic [Y_WIDTH-1:0] y);
        return (x <= X_MAX) && (y <= Y_MAX);
    endfunction

endpackage

// File: rtl/draw_instruction_executor_span_counter.sv
// Loadable x/y raster counter shared by HLINE and CLEAR.
// cursor_*_o is the look-ahead position: the pixel that will be on the bus after the next edge.
module draw_span_counter
    import draw_instruction_executor_pkg::*;
(
    input  logic               clock,
    input  logic               resetn,
    input  logic               load_i,
    input  logic               advance_i,
    input  logic [X_WIDTH-1:0] x0_i,
    input  logic [Y_WIDTH-1:0] y0_i,
    input  logic [X_WIDTH-1:0] x_end_i,
    input  logic               wrap_rows_i,
    output logic [X_WIDTH-1:0] cursor_x_o,
    output logic [Y_WIDTH-1:0] cursor_y_o,
    output logic               last_o
);

    logic [X_WIDTH-1:0] x_q, x_d;
    logic [Y_WIDTH-1:0] y_q, y_d;
    logic [X_WIDTH-1:0] x_end_q, x_end_d;
    logic               wrap_q, wrap_d;

    assign last_o = (x_q == x_end_q) && (!wrap_q || (y_q == Y_MAX));

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        x_end_d = x_end_q;
        wrap_d  = wrap_q;
        if (load_i) begin
            x_d     = x0_i;
            y_d     = y0_i;
            x_end_d = x_end_i;
            wrap_d  = wrap_rows_i;
        end else if (advance_i && !last_o) begin
            if (x_q == x_end_q) begin
                x_d = '0;
                y_d = y_q + 7'd1;
            end else begin
                x_d = x_q + 8'd1;
            end
        end
    end

    assign cursor_x_o = x_d;
    assign cursor_y_o = y_d;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x_q     <= '0;
            y_q     <= '0;
            x_end_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            x_end_q <= x_end_d;
            wrap_q  <= wrap_d;
        end
    end

endmodule

// File: rtl/draw_instruction_executor.sv
// Executes one 32-bit draw instruction per start/finished handshake as a stream
// of single-pixel VGA adapter writes, then reports a status code.
module draw_instruction_executor
    import draw_instruction_executor_pkg::*;
(
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    start,
    input  logic [31:0]             instruction,
    output logic                    finished,
    output logic [RESULT_WIDTH-1:0] result,
    output logic [X_WIDTH-1:0]      vga_x,
    output logic [Y_WIDTH-1:0]      vga_y,
    output logic [COLOUR_WIDTH-1:0] vga_colour,
    output logic                    vga_plot
);

    instr_t ins;
    assign ins = instruction;

    logic [2:0]              state_q, state_d;
    logic                    finished_q, finished_d;
    logic [RESULT_WIDTH-1:0] result_q, result_d;
    logic [RESULT_WIDTH-1:0] res_q, res_d;
    logic [COLOUR_WIDTH-1:0] colour_q, colour_d;
    logic                    plot_en_q, plot_en_d;
    logic [X_WIDTH-1:0]      vga_x_q, vga_x_d;
    logic [Y_WIDTH-1:0]      vga_y_q, vga_y_d;
    logic [COLOUR_WIDTH-1:0] vga_colour_q, vga_colour_d;
    logic                    vga_plot_q, vga_plot_d;

    logic               accept;
    logic               span_load, span_adv, span_wrap, span_last;
    logic [X_WIDTH-1:0] span_x0, span_x_end, cursor_x;
    logic [Y_WIDTH-1:0] span_y0, cursor_y;
    logic               write;

    // Ten bits so that x + arg - 1 (up to 669) can never wrap.
    logic [9:0] hl_last;
    logic       hl_clipped;
    assign hl_last    = {2'b00, ins.x} + {1'b0, ins.arg} - 10'd1;
    assign hl_clipped = hl_last > {2'b00, X_MAX};

    assign accept = start && finished_q;

    always_comb begin
        state_d    = state_q;
        finished_d = finished_q;
        result_d   = result_q;
        res_d      = res_q;
        colour_d   = colour_q;
        plot_en_d  = plot_en_q;
        span_load  = 1'b0;
        span_adv   = 1'b0;
        span_x0    = ins.x;
        span_y0    = ins.y;
        span_x_end = ins.x;
        span_wrap  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    finished_d = 1'b0;
                    plot_en_d  = ins.plot_en;
                    colour_d   = ins.colour;
                    state_d    = ST_PIXEL;
                    res_d      = RES_OK;
                    case (ins.op)
                        OP_NOP: ;
                        OP_PLOT: begin
                            if (on_screen(ins.x, ins.y)) span_load = 1'b1;
                            else                         res_d     = RES_RANGE;
                        end
                        OP_HLINE: begin
                            if (ins.arg == 9'd0) begin
                                res_d = RES_OK;
                            end else if (!on_screen(ins.x, ins.y)) begin
                                res_d = RES_RANGE;
                            end else begin
                                span_load  = 1'b1;
                                span_x_end = hl_clipped ? X_MAX : hl_last[7:0];
                                state_d    = ST_SPAN;
                                res_d      = hl_clipped ? RES_CLIPPED : RES_OK;
                            end
                        end
                        OP_CLEAR: begin
                            span_load  = 1'b1;
                            span_x0    = '0;
                            span_y0    = '0;
                            span_x_end = X_MAX;
                            span_wrap  = 1'b1;
                            state_d    = ST_CLEAR;
                        end
                        default: res_d = RES_BAD_OPCODE;
                    endcase
                end
            end
            ST_SPAN, ST_CLEAR: begin
                if (span_last) begin
                    state_d    = ST_DONE;
                    finished_d = 1'b1;
                    result_d   = res_q;
                end else begin
                    span_adv = 1'b1;
                end
            end
            default: begin
                state_d    = ST_DONE;
                finished_d = 1'b1;
                result_d   = res_q;
            end
        endcase
    end

    // Pixel outputs only move on a real write, so a dry run leaves them untouched.
    assign write        = (span_load || span_adv) && plot_en_d;
    assign vga_plot_d   = write;
    assign vga_x_d      = write ? cursor_x : vga_x_q;
    assign vga_y_d      = write ? cursor_y : vga_y_q;
    assign vga_colour_d = write ? colour_d : vga_colour_q;

    draw_span_counter u_span (
        .clock       (clock),
        .resetn      (resetn),
        .load_i      (span_load),
        .advance_i   (span_adv),
        .x0_i        (span_x0),
        .y0_i        (span_y0),
        .x_end_i     (span_x_end),
        .wrap_rows_i (span_wrap),
        .cursor_x_o  (cursor_x),
        .cursor_y_o  (cursor_y),
        .last_o      (span_last)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            finished_q   <= 1'b1;
            result_q     <= RES_OK;
            res_q        <= RES_OK;
            colour_q     <= '0;
            plot_en_q    <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            finished_q   <= finished_d;
            result_q     <= result_d;
            res_q        <= res_d;
            colour_q     <= colour_d;
            plot_en_q    <= plot_en_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
        end
    end

    assign finished   = finished_q;
    assign result     = result_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;

endmodule

// File: tb/tb_draw_instruction_executor.sv
// Directed and random instructions checked against a pixel-list reference model.
module tb_draw_instruction_executor;

    logic        clock = 1'b0;
    logic        resetn;
    logic        start;
    logic [31:0] instruction;
    logic        finished;
    logic [7:0]  result;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;

    draw_instruction_executor dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .instruction (instruction),
        .finished    (finished),
        .result      (result),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model state: expected pixel list, result, busy cycles, last written pixel.
    int exp_x[$];
    int exp_y[$];
    int exp_c[$];
    int exp_res;
    int exp_busy;
    int last_x = 0, last_y = 0, last_c = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int op, input int arg, input int pe,
                                       input int c, input int y, input int x);
        logic [31:0] w;
        w = {op[3:0], arg[8:0], pe[0], c[2:0], y[6:0], x[7:0]};
        return w;
    endfunction

    function automatic logic [31:0] pix(input int x, input int y, input int c);
        return 32'((x << 10) | (y << 3) | c);
    endfunction

    task automatic model(input logic [31:0] ins);
        int op, arg, pe, c, y, x;
        op  = int'(ins[31:28]);
        arg = int'(ins[27:19]);
        pe  = int'(ins[18]);
        c   = int'(ins[17:15]);
        y   = int'(ins[14:8]);
        x   = int'(ins[7:0]);
        exp_x.delete(); exp_y.delete(); exp_c.delete();
        exp_res = 0;
        if (op == 1) begin
            if (x < 160 && y < 120) begin
                exp_x.push_back(x); exp_y.push_back(y); exp_c.push_back(c);
            end else exp_res = 2;
        end else if (op == 2) begin
            if (arg != 0) begin
                if (x >= 160 || y >= 120) exp_res = 2;
                else begin
                    for (int i = 0; i < arg; i++)
                        if (x + i < 160) begin
                            exp_x.push_back(x + i); exp_y.push_back(y); exp_c.push_back(c);
                        end
                    if (x + arg > 160) exp_res = 3;
                end
            end
        end else if (op == 3) begin
            for (int yy = 0; yy < 120; yy++)
                for (int xx = 0; xx < 160; xx++) begin
                    exp_x.push_back(xx); exp_y.push_back(yy); exp_c.push_back(c);
                end
        end else if (op != 0) begin
            exp_res = 1;
        end
        exp_busy = (exp_x.size() > 0) ? exp_x.size() : 1;
        if (pe == 0) begin
            exp_x.delete(); exp_y.delete(); exp_c.delete();
        end
    endtask

    // One accept pulse, then watch the pixel stream until finished returns.
    task automatic run(input logic [31:0] ins, input string tag);
        int k, n;
        logic done;
        model(ins);
        start = 1'b1;
        instruction = ins;
        @(posedge clock); #1;
        start = 1'b0;
        k = 0; n = 0; done = 1'b0;
        while (!done && k < 20000) begin
            k++;
            if (vga_plot === 1'b1) begin
                if (n < exp_x.size())
                    chk({tag, " pixel"}, {14'd0, vga_x, vga_y, vga_colour}, pix(exp_x[n], exp_y[n], exp_c[n]));
                n++;
            end
            if (finished === 1'b1) done = 1'b1;
            else begin
                @(posedge clock); #1;
            end
        end
        if (exp_x.size() > 0) begin
            last_x = exp_x[exp_x.size()-1];
            last_y = exp_y[exp_y.size()-1];
            last_c = exp_c[exp_c.size()-1];
        end
        chk({tag, " latency"}, k, exp_busy + 1);
        chk({tag, " pulses"}, n, exp_x.size());
        chk({tag, " result"}, {24'd0, result}, exp_res);
        chk({tag, " plot_idle"}, {31'd0, vga_plot}, 0);
        chk({tag, " hold"}, {14'd0, vga_x, vga_y, vga_colour}, pix(last_x, last_y, last_c));
        $display("instr %s op=%0d -> result=%0d pulses=%0d cycles=%0d", tag, ins[31:28], result, n, k);
    endtask

    initial begin
        int pulses;
        resetn = 1'b0;
        start = 1'b1;
        instruction = mk(1, 0, 1, 3, 7, 5);

        // Reset held with start asserted: nothing may be accepted.
        repeat (3) @(posedge clock);
        #1;
        chk("reset finished", {31'd0, finished}, 1);
        chk("reset plot", {31'd0, vga_plot}, 0);
        chk("reset result", {24'd0, result}, 0);
        chk("reset pixel", {14'd0, vga_x, vga_y, vga_colour}, 0);
        start = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock); #1;
        chk("idle finished", {31'd0, finished}, 1);

        run(mk(1, 0, 1, 3, 7, 5), "plot_5_7");
        run(mk(2, 20, 1, 6, 10, 150), "hline_clip");
        run(mk(2, 0, 1, 6, 10, 20), "hline_len0");
        run(mk(2, 5, 1, 1, 119, 0), "hline_edge");
        run(mk(9, 0, 1, 1, 0, 0), "bad_op9");
        run(mk(1, 0, 1, 4, 3, 200), "plot_x200");
        run(mk(1, 0, 1, 4, 120, 10), "plot_y120");
        run(mk(0, 0, 1, 0, 0, 0), "nop");
        run(mk(3, 0, 1, 2, 0, 0), "clear_2");
        run(mk(2, 30, 0, 5, 50, 40), "hline_dry");
        run(mk(1, 0, 0, 5, 50, 40), "plot_dry");

        // start held high: the same PLOT runs twice back to back.
        start = 1'b1;
        instruction = mk(1, 0, 1, 5, 30, 20);
        pulses = 0;
        @(posedge clock); #1;
        pulses += int'(vga_plot);
        @(posedge clock); #1;
        chk("rerun finished_high", {31'd0, finished}, 1);
        @(posedge clock); #1;
        pulses += int'(vga_plot);
        chk("rerun busy_again", {31'd0, finished}, 0);
        start = 1'b0;
        @(posedge clock); #1;
        chk("rerun pulses", pulses, 2);
        chk("rerun done", {31'd0, finished}, 1);
        $display("instr rerun plot held start -> pulses=%0d", pulses);
        last_x = 20; last_y = 30; last_c = 5;

        run(mk(12, 0, 1, 0, 0, 0), "bad_op12");

        // Reset in the middle of a CLEAR.
        start = 1'b1;
        instruction = mk(3, 0, 1, 7, 0, 0);
        @(posedge clock); #1;
        start = 1'b0;
        repeat (200) @(posedge clock);
        #1;
        chk("midclear plotting", {31'd0, vga_plot}, 1);
        resetn = 1'b0;
        #1;
        chk("midclear plot_off", {31'd0, vga_plot}, 0);
        chk("midclear finished", {31'd0, finished}, 1);
        chk("midclear result", {24'd0, result}, 0);
        chk("midclear pixel", {14'd0, vga_x, vga_y, vga_colour}, 0);
        $display("instr reset mid-clear -> plot=%0d finished=%0d", vga_plot, finished);
        last_x = 0; last_y = 0; last_c = 0;
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock); #1;
        run(mk(1, 0, 1, 6, 100, 120), "plot_after_reset");

        for (int i = 0; i < 40; i++) begin
            int sel, op, x, y, arg, pe, c;
            sel = $urandom_range(0, 9);
            x   = $urandom_range(0, 180);
            y   = $urandom_range(0, 127);
            c   = $urandom_range(0, 7);
            pe  = ($urandom_range(0, 4) != 0) ? 1 : 0;
            arg = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 30);
            if (sel == 0)      op = 0;
            else if (sel <= 3) op = 1;
            else if (sel <= 7) op = 2;
            else               op = $urandom_range(4, 15);
            if (op == 2 && arg == 0) begin
                x = x % 160;
                y = y % 120;
            end
            run(mk(op, arg, pe, c, y, x), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
